mini_soc_pipe: RTL and testbench
================================

MINI_SOC_PIPE -- requirements
Module: mini_soc_pipe

Interface
REQ-001 Parameter WIDTH, default 8, datapath width of operands, ALU, accumulator, counter and soc_out; legal range 2..32.
REQ-002 Parameter CNT_STEP, default 1, increment applied to the free-running counter each cycle.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 Port op_a, op_b  input  WIDTH each  operands.
REQ-008 Port alu_op  input  2  00 ADD, 01 SUB (a-b), 10 AND, 11 XOR; sampled with the beat.
REQ-009 Port mux_sel  input  2  output source; sampled with the beat: 00 ALU result, 01 accumulator, 10 counter, 11 registered op_a.
REQ-010 Port acc_clr  input  1  synchronous accumulator clear, level-sensitive.
REQ-011 Port out_valid  output  1  soc_out/flag hold a result.
REQ-012 Port out_ready  input  1  downstream accepts result.
REQ-013 Port soc_out  output  WIDTH  selected result.
REQ-014 Port flag  output  1  carry (ADD), borrow (SUB), zero-result (AND/XOR) for the beat.

Function
REQ-015 Two register stages: S1 captures {op_a, op_b, alu_op, mux_sel} on in_valid && in_ready; S2 computes and holds the output.
REQ-016 Beat accepted at edge N SHALL appear with out_valid=1 after edge N+1 when out_ready was high (latency 2 edges, throughput 1 beat/cycle).
REQ-017 S2 advances when !out_valid || out_ready; S1 advances into S2 under the same condition.
REQ-018 in_ready = !s1_valid || s2_advance (combinational, no dependence on in_valid).
REQ-019 While out_valid && !out_ready, soc_out, flag and out_valid SHALL hold stable; no beat is dropped or duplicated.
REQ-020 ALU arithmetic modulo 2^WIDTH; ADD carry = bit WIDTH of a+b; SUB borrow = (a<b).
REQ-021 Accumulator updates only when a beat moves S1->S2: acc <= acc + alu_result, wrap modulo 2^WIDTH.
REQ-022 mux_sel=01 outputs the accumulator value after that beat's update.
REQ-023 Counter increments by CNT_STEP every cycle regardless of handshake, wraps modulo 2^WIDTH; mux_sel=10 outputs its value at the S1->S2 edge.
REQ-024 acc_clr=1 sets acc to 0 at the edge; simultaneous with a beat update, clear wins and the beat's accumulated output is 0.
REQ-025 flag for mux_sel 01/10/11 SHALL still reflect the ALU result of the beat.

Reset
REQ-026 rst_n=0 SHALL immediately clear s1_valid, out_valid, acc, counter, soc_out, flag to 0; in_ready=1 once reset deasserts.
REQ-027 Reset mid-operation discards all in-flight beats; no output beat issued for them.

Structure
REQ-028 Shared package mini_soc_pkg holds alu_op encodings (ADD/SUB/AND/XOR) and mux_sel encodings (SRC_ALU/SRC_ACC/SRC_CNT/SRC_OPA).
REQ-029 Combinational ALU is a sub-module mini_soc_alu (WIDTH-parametrised, outputs result and flag); pipeline, accumulator, counter and handshake stay in the top.

Verification
REQ-030 Reset: rst_n low mid-stream with 2 beats in flight -> out_valid=0, acc=0, counter=0 immediately; no stale beat after release.
REQ-031 WIDTH=8 ADD 200+100, mux_sel=00 -> soc_out=44, flag=1, two edges after acceptance.
REQ-032 Backpressure: out_ready=0 for 5 cycles, in_valid=1 continuous -> exactly 2 beats held, in_ready=0, soc_out stable; release -> beats in order, none lost.
REQ-033 Accumulator: beats ADD 3+4, SUB 10-2, mux_sel=01 -> soc_out 7 then 15; acc_clr with third beat -> 0.
REQ-034 Counter: CNT_STEP=1, beat mux_sel=10 at cycle 300 after reset -> soc_out equals counter modulo 256 (wrap checked).
REQ-035 WIDTH=16 SUB 0-1, mux_sel=00 -> soc_out=16'hFFFF, flag=1; XOR equal operands -> 0, flag=1.

Source files
------------

// File: rtl/mini_soc_pkg.sv
// Shared encodings for the mini SoC pipeline: ALU opcodes and output-source selects.
package mini_soc_pkg;

  typedef logic [1:0] alu_op_t;
  typedef logic [1:0] mux_sel_t;

  // ALU operation encodings
  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_XOR = 2'b11;

  // Output source encodings
  localparam mux_sel_t SRC_ALU = 2'b00;
  localparam mux_sel_t SRC_ACC = 2'b01;
  localparam mux_sel_t SRC_CNT = 2'b10;
  localparam mux_sel_t SRC_OPA = 2'b11;

endpackage

// File: rtl/mini_soc_alu.sv
// Combinational ALU: ADD/SUB/AND/XOR with carry, borrow or zero flag.
module mini_soc_alu
  import mini_soc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] xor_s;

  // Widened add/sub so the top bit carries the carry-out or the borrow (a < b)
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    and_s  = a & b;
    xor_s  = a ^ b;
  end

  // Select the result and its flag for the requested operation
  always_comb begin
    result = {WIDTH{1'b0}};
    flag   = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum_s[WIDTH-1:0];
        flag   = sum_s[WIDTH];
      end
      ALU_SUB: begin
        result = diff_s[WIDTH-1:0];
        flag   = diff_s[WIDTH];
      end
      ALU_AND: begin
        result = and_s;
        flag   = (and_s == {WIDTH{1'b0}});
      end
      ALU_XOR: begin
        result = xor_s;
        flag   = (xor_s == {WIDTH{1'b0}});
      end
      default: begin
        result = {WIDTH{1'b0}};
        flag   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mini_soc_pipe.sv
// Two-stage valid/ready pipeline: S1 captures the operand beat, S2 computes and
// holds the selected result. Also hosts the accumulator and free-running counter.
module mini_soc_pipe
  import mini_soc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       mux_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] soc_out,
  output logic             flag
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(CNT_STEP);

  // Stage 1 beat registers
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [1:0]       s1_op_r;
  logic [1:0]       s1_sel_r;

  // Stage 2 / output registers
  logic             out_valid_r;
  logic [WIDTH-1:0] soc_out_r;
  logic             flag_r;

  // Accumulator and counter
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] cnt_r;

  // Handshake and datapath nets
  logic             s2_adv_s;
  logic             accept_s;
  logic             move_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_flag_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] out_next_s;

  mini_soc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (s1_a_r),
    .b      (s1_b_r),
    .op     (s1_op_r),
    .result (alu_res_s),
    .flag   (alu_flag_s)
  );

  // Handshake: S2 frees up when empty or drained; S1 may take a beat when it
  // is empty or its beat is moving on this edge
  always_comb begin
    s2_adv_s = !out_valid_r || out_ready;
    in_ready = !s1_valid_r || s2_adv_s;
    accept_s = in_valid && in_ready;
    move_s   = s1_valid_r && s2_adv_s;
  end

  // Next accumulator value for a moving beat (clear wins) and output source mux
  always_comb begin
    if (acc_clr) begin
      acc_next_s = {WIDTH{1'b0}};
    end else begin
      acc_next_s = acc_r + alu_res_s;
    end
    case (s1_sel_r)
      SRC_ALU: out_next_s = alu_res_s;
      SRC_ACC: out_next_s = acc_next_s;
      SRC_CNT: out_next_s = cnt_r;
      SRC_OPA: out_next_s = s1_a_r;
      default: out_next_s = alu_res_s;
    endcase
  end

  // Stage 1 capture of the operand beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 2'b00;
      s1_sel_r   <= 2'b00;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= op_a;
      s1_b_r     <= op_b;
      s1_op_r    <= alu_op;
      s1_sel_r   <= mux_sel;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 result register; holds while the downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      soc_out_r   <= {WIDTH{1'b0}};
      flag_r      <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        soc_out_r <= out_next_s;
        flag_r    <= alu_flag_s;
      end
    end
  end

  // Accumulator: level clear, otherwise add each beat as it enters S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (acc_clr) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (move_s) begin
      acc_r <= acc_next_s;
    end
  end

  // Free-running counter, independent of the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_r + STEP;
    end
  end

  assign out_valid = out_valid_r;
  assign soc_out   = soc_out_r;
  assign flag      = flag_r;

endmodule

// File: tb/tb_mini_soc_pipe.sv
// Self-checking bench: WIDTH=8 instance against a cycle-level behavioural model
// with randomized traffic plus directed literal checks; WIDTH=16 instance for
// wide-arithmetic corner cases.
module tb_mini_soc_pipe;

  localparam int W    = 8;
  localparam int M    = (1 << W) - 1;
  localparam int STEP = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] alu_op;
  logic [1:0] mux_sel;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] soc_out;
  logic       flag;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] op_a16;
  logic [15:0] op_b16;
  logic [1:0]  alu_op16;
  logic [1:0]  mux_sel16;
  logic        acc_clr16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] soc_out16;
  logic        flag16;

  int checks;
  int failures;

  mini_soc_pipe #(.WIDTH(8), .CNT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .mux_sel(mux_sel),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .soc_out(soc_out), .flag(flag)
  );

  mini_soc_pipe #(.WIDTH(16), .CNT_STEP(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .op_a(op_a16), .op_b(op_b16), .alu_op(alu_op16), .mux_sel(mux_sel16),
    .acc_clr(acc_clr16), .out_valid(out_valid16), .out_ready(out_ready16),
    .soc_out(soc_out16), .flag(flag16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Specification-level ALU: plain integer arithmetic
  function automatic void alu_model(input int a, input int b, input int op,
                                    output int r, output int f);
    int s;
    case (op)
      0: begin s = a + b; r = s & M; f = (s > M) ? 1 : 0; end
      1: begin r = (a - b) & M; f = (a < b) ? 1 : 0; end
      2: begin r = a & b; f = (r == 0) ? 1 : 0; end
      default: begin r = a ^ b; f = (r == 0) ? 1 : 0; end
    endcase
  endfunction

  // Model state: beat waiting to be computed, beat on the output, acc, cycle count
  int m_mid_v, m_mid_a, m_mid_b, m_mid_op, m_mid_sel;
  int m_out_v, m_out, m_flag;
  int m_acc, m_cnt;

  task automatic model_clear();
    m_mid_v = 0; m_out_v = 0; m_out = 0; m_flag = 0; m_acc = 0; m_cnt = 0;
  endtask

  // Model step at each rising edge, compare against the DUT at each falling edge
  initial begin
    int adv, acc_in, r, f, o;
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        adv    = (!m_out_v || out_ready) ? 1 : 0;
        acc_in = (in_valid && (!m_mid_v || adv)) ? 1 : 0;
        if (adv) begin
          if (m_mid_v) begin
            alu_model(m_mid_a, m_mid_b, m_mid_op, r, f);
            m_acc = acc_clr ? 0 : ((m_acc + r) & M);
            case (m_mid_sel)
              0: o = r;
              1: o = m_acc;
              2: o = m_cnt;
              default: o = m_mid_a;
            endcase
            m_out = o; m_flag = f;
          end else if (acc_clr) begin
            m_acc = 0;
          end
          m_out_v = m_mid_v;
        end else if (acc_clr) begin
          m_acc = 0;
        end
        if (acc_in) begin
          m_mid_v = 1; m_mid_a = op_a; m_mid_b = op_b;
          m_mid_op = alu_op; m_mid_sel = mux_sel;
        end else if (adv) begin
          m_mid_v = 0;
        end
        m_cnt = (m_cnt + STEP) & M;
      end
      @(negedge clk);
      if (!rst_n) model_clear();
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (!m_mid_v || !m_out_v || out_ready) ? 1'b1 : 1'b0});
      chk("out_valid", {31'd0, out_valid}, m_out_v);
      if (m_out_v) begin
        chk("soc_out", {24'd0, soc_out}, m_out);
        chk("flag", {31'd0, flag}, m_flag);
      end
    end
  end

  // Offer one beat to an idle WIDTH=8 pipeline and check it two edges later
  task automatic send_check(input int a, input int b, input int op, input int sel,
                            input logic clr, input int exp_out, input int exp_flag,
                            input string name);
    op_a = a[7:0]; op_b = b[7:0]; alu_op = op[1:0]; mux_sel = sel[1:0];
    acc_clr = clr; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    acc_clr = 1'b0;
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_out"}, {24'd0, soc_out}, exp_out);
    chk({name, "_flag"}, {31'd0, flag}, exp_flag);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [15:0] exp_out, input logic exp_flag, input string name);
    op_a16 = a; op_b16 = b; alu_op16 = op; mux_sel16 = 2'b00; in_valid16 = 1'b1;
    @(posedge clk); #2;
    in_valid16 = 1'b0;
    @(posedge clk); #2;
    chk({name, "_valid"}, {31'd0, out_valid16}, 32'd1);
    chk({name, "_out"}, {16'd0, soc_out16}, {16'd0, exp_out});
    chk({name, "_flag"}, {31'd0, flag16}, {31'd0, exp_flag});
  endtask

  initial begin
    int nacc;
    logic rdy;
    logic [7:0] q[$];
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; op_a = 8'd0; op_b = 8'd0; alu_op = 2'b00;
    mux_sel = 2'b00; acc_clr = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; op_a16 = 16'd0; op_b16 = 16'd0; alu_op16 = 2'b00;
    mux_sel16 = 2'b00; acc_clr16 = 1'b0; out_ready16 = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_soc_out", {24'd0, soc_out}, 32'd0);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;

    // Reset with two beats in flight
    out_ready = 1'b0;
    op_a = 8'd5; op_b = 8'd6; alu_op = 2'b00; mux_sel = 2'b00; in_valid = 1'b1;
    @(posedge clk); #2;
    op_a = 8'd9; op_b = 8'd1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_soc_out", {24'd0, soc_out}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
    end

    // Counter: move edge 301 after release -> value 300 mod 256 = 44
    repeat (299 - 4) @(posedge clk);
    #2;
    send_check(0, 0, 0, 2, 1'b0, 44, 0, "cnt300");

    // Accumulator starts at 0 after reset
    send_check(3, 4, 0, 1, 1'b0, 7, 0, "acc_add");
    send_check(10, 2, 1, 1, 1'b0, 15, 0, "acc_sub");
    send_check(1, 1, 0, 1, 1'b1, 0, 0, "acc_clr");

    // ADD 200+100 wraps to 44 with carry
    send_check(200, 100, 0, 0, 1'b0, 44, 1, "add_carry");
    send_check(5, 9, 1, 0, 1'b0, 252, 1, "sub_borrow");
    send_check(8'hF0, 8'h0F, 2, 3, 1'b0, 8'hF0, 1, "and_zero_opa");

    // WIDTH=16 corners
    send16(16'd0, 16'd1, 2'b01, 16'hFFFF, 1'b1, "w16_sub");
    send16(16'h1234, 16'h1234, 2'b11, 16'h0000, 1'b1, "w16_xor");

    // Backpressure: out_ready low for 5 cycles with continuous in_valid
    repeat (3) @(posedge clk);
    #2;
    out_ready = 1'b0; nacc = 0;
    op_a = 8'd10; op_b = 8'd0; alu_op = 2'b00; mux_sel = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdy = in_ready;
      @(posedge clk); #2;
      if (rdy) begin
        nacc++;
        op_a = 8'(10 + nacc);
      end
      if (i >= 1) chk("bp_hold_out", {24'd0, soc_out}, 32'd10);
    end
    chk("bp_accepted", nacc, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) q.push_back(soc_out);
      @(posedge clk); #2;
    end
    chk("bp_count", q.size(), 32'd2);
    if (q.size() >= 2) begin
      chk("bp_first", {24'd0, q[0]}, 32'd10);
      chk("bp_second", {24'd0, q[1]}, 32'd11);
    end

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = (i % 500 < 100) ? 1'b1 : ($urandom_range(0, 9) < 6);
      op_a      = 8'($urandom);
      op_b      = 8'($urandom);
      alu_op    = 2'($urandom);
      mux_sel   = 2'($urandom);
      acc_clr   = ($urandom_range(0, 15) == 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
